adc_capture_buffer: RTL
=======================

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of buffer depth; DEPTH = 2^ADDR_WIDTH samples.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, meaning sample width.
REQ-003 The module SHALL have port aclk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port areset, input, 1, meaning synchronous active-high reset.
REQ-005 The module SHALL have port arm, input, 1, meaning start-capture request, sampled each cycle.
REQ-006 The module SHALL have port flush, input, 1, meaning end capture early and start readout.
REQ-007 The module SHALL have port s_axis_tvalid, input, 1, meaning input sample valid (no tready; the upstream stage cannot stall).
REQ-008 The module SHALL have port s_axis_tdata, input, DATA_WIDTH, meaning input sample (sum of absolute ADC values).
REQ-009 The module SHALL have port m_axis_tready, input, 1, meaning downstream accepts a word.
REQ-010 The module SHALL have port m_axis_tvalid, output, 1, meaning readout word valid.
REQ-011 The module SHALL have port m_axis_tdata, output, DATA_WIDTH, meaning readout word.
REQ-012 The module SHALL have port m_axis_tlast, output, 1, meaning last word of the capture.
REQ-013 The module SHALL have port state, output, 2, meaning 0 IDLE, 1 CAPTURE, 2 READOUT.
REQ-014 The module SHALL have port sample_count, output, ADDR_WIDTH+1, meaning samples stored in the current or most recent capture.
REQ-015 The module SHALL have port drop_count, output, 16, meaning saturating count of input samples discarded outside CAPTURE.
REQ-016 The module SHALL have port done, output, 1, meaning one-cycle pulse after the final readout handshake.

Function
REQ-017 The module SHALL implement an FSM with states IDLE, CAPTURE and READOUT, plus a DEPTH x DATA_WIDTH single-clock RAM with 1-cycle registered read.
REQ-018 In IDLE, arm=1 SHALL clear sample_count and the write pointer and go to CAPTURE on the next cycle; flush in IDLE SHALL be ignored.
REQ-019 In CAPTURE, each cycle with s_axis_tvalid=1 SHALL write s_axis_tdata at the write pointer and increment both the pointer and sample_count.
REQ-020 CAPTURE SHALL go to READOUT in the cycle after the write that makes sample_count = DEPTH (full); that write SHALL be stored.
REQ-021 flush=1 in CAPTURE SHALL go to READOUT if sample_count (including any write in the same cycle) > 0, and to IDLE with a done pulse if it is 0.
REQ-022 When full and flush coincide, full SHALL take precedence; the result is the same transition.
REQ-023 In IDLE or READOUT, every s_axis_tvalid=1 cycle SHALL increment drop_count, saturating at 16'hFFFF; drop_count SHALL be cleared only by reset or by arm accepted in IDLE.
REQ-024 arm in CAPTURE or READOUT SHALL be ignored.
REQ-025 READOUT SHALL present words in write order (address 0 to sample_count-1); the first m_axis_tvalid SHALL assert exactly 2 cycles after entering READOUT.
REQ-026 A word SHALL transfer only on a cycle with m_axis_tvalid=1 and m_axis_tready=1; while m_axis_tready=0, m_axis_tvalid, tdata and tlast SHALL stay stable.
REQ-027 After the first word, back-to-back words SHALL transfer on consecutive cycles while m_axis_tready=1, with no bubbles; a prefetch or skid register is required to meet this.
REQ-028 m_axis_tlast SHALL be 1 only on the word at address sample_count-1.
REQ-029 After the tlast handshake, the module SHALL deassert m_axis_tvalid, pulse done for one cycle and go to IDLE on the next cycle.
REQ-030 sample_count SHALL hold its value in IDLE until the next accepted arm.

Reset
REQ-031 With areset=1 at a clock edge, state SHALL go to IDLE, and m_axis_tvalid, m_axis_tlast, m_axis_tdata, done, sample_count, drop_count and all pointers SHALL be 0.
REQ-032 Reset SHALL take precedence over every other input in any state, including mid-capture and mid-readout; RAM contents need not be cleared.

Verification
REQ-033 Scenario: ADDR_WIDTH=3; arm, then 8 continuous valid samples 1..8 with tready=1 -> READOUT, and 8 words 1..8 on consecutive cycles, tlast on 8, done pulse, return to IDLE, sample_count=8.
REQ-034 Scenario: arm, 3 samples 0x10,0x20,0x30, flush -> words 0x10,0x20,0x30, tlast on 0x30, sample_count=3.
REQ-035 Scenario: readout with tready toggling 1,0,0,1 -> no word lost or duplicated, outputs stable while tready=0.
REQ-036 Scenario: 5 valid samples in IDLE, then arm -> drop_count reads 5 before arm and 0 after; with 70000 valid samples in IDLE, drop_count reads 0xFFFF.
REQ-037 Scenario: areset asserted mid-readout (after 2 of 8 words) -> next cycle state=0, m_axis_tvalid=0, sample_count=0; a new arm then captures normally.
REQ-038 Scenario: flush with sample_count=0 -> done pulse, state stays IDLE, no m_axis_tvalid.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: captures a burst of ADC samples into a RAM and streams them out with AXI-Stream handshaking.
module adc_capture_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  arm,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH:0]   sample_count,
  output logic [15:0]           drop_count,
  output logic                  done
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, READOUT = 2'd2} st_t;
  st_t st, st_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q, sk_data;
  logic [ADDR_WIDTH:0] cnt_after, rd_ptr;
  logic [1:0] occ;
  logic wr_en, pend, pend_last, sk_v, sk_last, pop, issue, last_hs, done_nx;
  assign state = st;
  assign wr_en = st == CAPTURE && s_axis_tvalid;
  assign cnt_after = sample_count + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign pop = m_axis_tvalid & m_axis_tready;
  assign last_hs = pop & m_axis_tlast;
  // Reads in flight plus buffered words never exceed the output+skid capacity of two.
  assign occ = {1'b0, m_axis_tvalid} + {1'b0, sk_v} + {1'b0, pend};
  assign issue = st == READOUT && rd_ptr < sample_count && (occ - {1'b0, pop}) < 2'd2;
  always_comb begin
    st_nx = st;
    done_nx = 1'b0;
    if (st == IDLE && arm)
      st_nx = CAPTURE;
    else if (st == CAPTURE && (cnt_after == FULL || (flush && cnt_after != '0)))
      st_nx = READOUT;
    else if ((st == CAPTURE && flush) || (st == READOUT && last_hs)) begin
      st_nx = IDLE;
      done_nx = 1'b1;
    end
  end
  always_ff @(posedge aclk)
    st <= areset ? IDLE : st_nx;
  always_ff @(posedge aclk) begin
    if (wr_en) mem[sample_count[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      sample_count <= '0;
      drop_count <= '0;
      rd_ptr <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      sk_v <= 1'b0;
      sk_last <= 1'b0;
      sk_data <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= done_nx;
      if (st == IDLE && arm) begin
        sample_count <= '0;
        drop_count <= '0;
      end else begin
        sample_count <= cnt_after;
        if (st != CAPTURE && s_axis_tvalid && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      rd_ptr <= st != READOUT ? '0 : rd_ptr + {{ADDR_WIDTH{1'b0}}, issue};
      pend <= issue;
      pend_last <= rd_ptr == sample_count - ONE;
      if (!m_axis_tvalid || pop) begin
        m_axis_tvalid <= sk_v | pend;
        m_axis_tlast <= sk_v ? sk_last : pend & pend_last;
        if (sk_v | pend) m_axis_tdata <= sk_v ? sk_data : ram_q;
        sk_v <= sk_v & pend;
        sk_data <= ram_q;
        sk_last <= pend_last;
      end else if (pend) begin
        sk_v <= 1'b1;
        sk_data <= ram_q;
        sk_last <= pend_last;
      end
    end
  end
endmodule
